// File: rtl/id_hazard_scoreboard.sv
//------------------------------------------------------------------------------
// Module  : id_hazard_scoreboard
// Brief   : Per-register RAW/WAW latency scoreboard that stalls ID issue.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module id_hazard_scoreboard #(
  parameter int REG_NUM = 32,
  parameter int AW      = 5,
  parameter int MAX_LAT = 3,
  parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid_i,
  input  logic               rs_read_i,
  input  logic [AW-1:0]      rs_addr_i,
  input  logic               rt_read_i,
  input  logic [AW-1:0]      rt_addr_i,
  input  logic               wreg_i,
  input  logic [AW-1:0]      wd_i,
  input  logic [LAT_W-1:0]   wlat_i,
  input  logic               hilo_read_i,
  input  logic               hilo_write_i,
  input  logic [LAT_W-1:0]   hilo_lat_i,
  input  logic               ex_ready_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               issue_o,
  output logic [REG_NUM-1:0] busy_vec_o,
  output logic               hilo_busy_o,
  output logic [31:0]        stall_cnt_o
);

  localparam logic [LAT_W-1:0] c_MAX_LAT = LAT_W'(MAX_LAT);
  localparam logic [AW:0]      c_REG_NUM = (AW + 1)'(REG_NUM);

  logic [LAT_W-1:0]   r_cnt [REG_NUM];
  logic [LAT_W-1:0]   r_hilo_cnt;
  logic [31:0]        r_stall_cnt;

  logic               w_rs_ok, w_rt_ok, w_wd_ok;
  logic [LAT_W-1:0]   w_rs_cnt, w_rt_cnt, w_wd_cnt;
  logic               w_raw_hz, w_waw_hz;
  logic               w_live, w_set_gpr, w_set_hilo;
  logic [LAT_W-1:0]   w_wlat_sat, w_hlat_sat;
  logic [REG_NUM-1:0] w_busy;

  // Index 0 and anything beyond the register file behave as the zero register.
  function automatic logic f_real_reg(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < c_REG_NUM);
  endfunction

  assign w_rs_ok  = rs_read_i & f_real_reg(rs_addr_i);
  assign w_rt_ok  = rt_read_i & f_real_reg(rt_addr_i);
  assign w_wd_ok  = wreg_i    & f_real_reg(wd_i);
  assign w_rs_cnt = w_rs_ok ? r_cnt[rs_addr_i] : '0;
  assign w_rt_cnt = w_rt_ok ? r_cnt[rt_addr_i] : '0;
  assign w_wd_cnt = w_wd_ok ? r_cnt[wd_i]      : '0;

  assign w_raw_hz = (w_rs_cnt != '0) | (w_rt_cnt != '0) |
                    (hilo_read_i & (r_hilo_cnt != '0));
  // A younger write may issue once it cannot complete before the older one.
  assign w_waw_hz = (w_wd_cnt > wlat_i) | (hilo_write_i & (r_hilo_cnt > hilo_lat_i));

  assign w_live   = rst & id_valid_i & ~flush_i;
  assign stall_o  = w_live & (w_raw_hz | w_waw_hz | ~ex_ready_i);
  assign issue_o  = w_live & ex_ready_i & ~w_raw_hz & ~w_waw_hz;

  assign w_wlat_sat = (wlat_i     > c_MAX_LAT) ? c_MAX_LAT : wlat_i;
  assign w_hlat_sat = (hilo_lat_i > c_MAX_LAT) ? c_MAX_LAT : hilo_lat_i;
  assign w_set_gpr  = issue_o & w_wd_ok;
  assign w_set_hilo = issue_o & hilo_write_i;

  generate
    for (genvar i = 0; i < REG_NUM; i++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
          r_cnt[i] <= '0;
        end else if (ex_ready_i) begin
          if (w_set_gpr && (wd_i == AW'(i)))
            r_cnt[i] <= w_wlat_sat;
          else if (r_cnt[i] != '0)
            r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
      assign w_busy[i] = (r_cnt[i] != '0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      r_hilo_cnt <= '0;
    end else if (ex_ready_i) begin
      if (w_set_hilo)
        r_hilo_cnt <= w_hlat_sat;
      else if (r_hilo_cnt != '0)
        r_hilo_cnt <= r_hilo_cnt - 1'b1;
    end
  end

  // Perf counter survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst)
      r_stall_cnt <= '0;
    else if (stall_o && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign busy_vec_o  = rst ? w_busy : '0;
  assign hilo_busy_o = rst & (r_hilo_cnt != '0);
  assign stall_cnt_o = rst ? r_stall_cnt : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_id_hazard_scoreboard.sv
//------------------------------------------------------------------------------
// Module  : tb_id_hazard_scoreboard
// Brief   : Table-driven, scoreboard-checked bench for id_hazard_scoreboard.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_id_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i, rs_read_i, rt_read_i, wreg_i;
  logic [4:0]  rs_addr_i, rt_addr_i, wd_i;
  logic [1:0]  wlat_i, hilo_lat_i;
  logic        hilo_read_i, hilo_write_i, ex_ready_i, flush_i;
  logic        stall_o, issue_o, hilo_busy_o;
  logic [31:0] busy_vec_o, stall_cnt_o;

  always #5 clk = ~clk;

  id_hazard_scoreboard #(.REG_NUM(32), .AW(5), .MAX_LAT(3), .LAT_W(2)) dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i),
    .rs_read_i(rs_read_i), .rs_addr_i(rs_addr_i),
    .rt_read_i(rt_read_i), .rt_addr_i(rt_addr_i),
    .wreg_i(wreg_i), .wd_i(wd_i), .wlat_i(wlat_i),
    .hilo_read_i(hilo_read_i), .hilo_write_i(hilo_write_i), .hilo_lat_i(hilo_lat_i),
    .ex_ready_i(ex_ready_i), .flush_i(flush_i),
    .stall_o(stall_o), .issue_o(issue_o), .busy_vec_o(busy_vec_o),
    .hilo_busy_o(hilo_busy_o), .stall_cnt_o(stall_cnt_o)
  );

  typedef struct {
    logic        rst, valid, rs_rd, rt_rd, wreg, hr, hw, exr, fl;
    logic [4:0]  rs, rt, wd;
    logic [1:0]  wlat, hlat;
  } in_t;

  typedef struct {
    logic        stall, issue, hb;
    logic [31:0] busy, sc;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic in_t idle();
    in_t v = '{default: '0};
    v.rst = 1'b1;
    v.exr = 1'b1;
    return v;
  endfunction

  function automatic in_t wr(input logic [4:0] wd, input logic [1:0] lat);
    in_t v = idle();
    v.valid = 1'b1; v.wreg = 1'b1; v.wd = wd; v.wlat = lat;
    return v;
  endfunction

  function automatic in_t rd(input logic [4:0] rs);
    in_t v = idle();
    v.valid = 1'b1; v.rs_rd = 1'b1; v.rs = rs;
    return v;
  endfunction

  task automatic add(input in_t v, input logic st, input logic is,
                     input logic [31:0] b, input logic hb, input int sc);
    vec_t r;
    r.i = v;
    r.e = '{stall: st, issue: is, hb: hb, busy: b, sc: sc};
    tbl.push_back(r);
  endtask

  task automatic drive(input in_t v);
    rst = v.rst; id_valid_i = v.valid;
    rs_read_i = v.rs_rd; rs_addr_i = v.rs;
    rt_read_i = v.rt_rd; rt_addr_i = v.rt;
    wreg_i = v.wreg; wd_i = v.wd; wlat_i = v.wlat;
    hilo_read_i = v.hr; hilo_write_i = v.hw; hilo_lat_i = v.hlat;
    ex_ready_i = v.exr; flush_i = v.fl;
  endtask

  initial begin
    in_t  v;
    exp_t e;
    int   stalls;
    logic got_issue;

    v = wr(5'd3, 2'd2);
    v.rst = 1'b0;
    drive(v);

    // Reset held with a write pending: everything reads zero.
    add(v, 0, 0, 32'h0, 0, 0);
    add(v, 0, 0, 32'h0, 0, 0);
    // Load-use on r5 with latency 2.
    add(wr(5'd5, 2'd2), 0, 1, 32'h0, 0, 0);
    add(rd(5'd5), 1, 0, 32'h20, 0, 0);
    add(rd(5'd5), 1, 0, 32'h20, 0, 1);
    add(rd(5'd5), 0, 1, 32'h0, 0, 2);
    // Freeze: r7 latency 2 held across three not-ready cycles.
    add(wr(5'd7, 2'd2), 0, 1, 32'h0, 0, 2);
    v = rd(5'd7); v.exr = 1'b0;
    add(v, 1, 0, 32'h80, 0, 2);
    add(v, 1, 0, 32'h80, 0, 3);
    add(v, 1, 0, 32'h80, 0, 4);
    add(idle(), 0, 0, 32'h80, 0, 5);
    add(idle(), 0, 0, 32'h80, 0, 5);
    add(idle(), 0, 0, 32'h0, 0, 5);
    // WAW on r9: older lat 3, younger lat 1.
    add(wr(5'd9, 2'd3), 0, 1, 32'h0, 0, 5);
    add(wr(5'd9, 2'd1), 1, 0, 32'h200, 0, 5);
    add(wr(5'd9, 2'd1), 1, 0, 32'h200, 0, 6);
    add(wr(5'd9, 2'd1), 0, 1, 32'h200, 0, 7);
    add(idle(), 0, 0, 32'h200, 0, 7);
    add(idle(), 0, 0, 32'h0, 0, 7);
    // HI/LO: mult lat 3, mfhi stalls, flush clears it.
    v = idle(); v.valid = 1'b1; v.hw = 1'b1; v.hlat = 2'd3;
    add(v, 0, 1, 32'h0, 0, 7);
    v = idle(); v.valid = 1'b1; v.hr = 1'b1;
    add(v, 1, 0, 32'h0, 1, 7);
    add(v, 1, 0, 32'h0, 1, 8);
    v.fl = 1'b1;
    add(v, 0, 0, 32'h0, 1, 9);
    v.fl = 1'b0;
    add(v, 0, 1, 32'h0, 0, 9);
    // r0 writes never mark busy; same-index set beats decrement.
    add(wr(5'd0, 2'd3), 0, 1, 32'h0, 0, 9);
    add(idle(), 0, 0, 32'h0, 0, 9);
    add(wr(5'd4, 2'd1), 0, 1, 32'h0, 0, 9);
    add(wr(5'd4, 2'd2), 0, 1, 32'h10, 0, 9);
    add(idle(), 0, 0, 32'h10, 0, 9);
    add(idle(), 0, 0, 32'h10, 0, 9);
    add(idle(), 0, 0, 32'h0, 0, 9);
    // rt hazard, then an r0 read alone never stalls.
    add(wr(5'd6, 2'd2), 0, 1, 32'h0, 0, 9);
    v = rd(5'd0); v.rt_rd = 1'b1; v.rt = 5'd6;
    add(v, 1, 0, 32'h40, 0, 9);
    add(rd(5'd0), 0, 1, 32'h40, 0, 10);
    add(idle(), 0, 0, 32'h0, 0, 10);
    // A write issued alongside flush is dropped.
    v = wr(5'd8, 2'd3); v.fl = 1'b1;
    add(v, 0, 0, 32'h0, 0, 10);
    add(idle(), 0, 0, 32'h0, 0, 10);
    // Reset mid-flight clears counters and the perf count.
    add(wr(5'd10, 2'd3), 0, 1, 32'h0, 0, 10);
    v = rd(5'd10); v.rst = 1'b0;
    add(v, 0, 0, 32'h0, 0, 0);
    add(idle(), 0, 0, 32'h0, 0, 0);

    foreach (tbl[k]) begin
      @(negedge clk);
      drive(tbl[k].i);
      sb.push_back(tbl[k].e);
      #2;
      e = sb.pop_front();
      chk($sformatf("row%0d.stall", k), 32'(stall_o), 32'(e.stall));
      chk($sformatf("row%0d.issue", k), 32'(issue_o), 32'(e.issue));
      chk($sformatf("row%0d.busy", k), busy_vec_o, e.busy);
      chk($sformatf("row%0d.hilo_busy", k), 32'(hilo_busy_o), 32'(e.hb));
      chk($sformatf("row%0d.stall_cnt", k), stall_cnt_o, e.sc);
    end

    // Poll a dependent read until it issues; latency 3 must cost 3 stalls.
    @(negedge clk);
    drive(wr(5'd12, 2'd3));
    #2;
    chk("poll.producer_issue", 32'(issue_o), 32'd1);
    stalls    = 0;
    got_issue = 1'b0;
    for (int n = 0; n < 10 && !got_issue; n++) begin
      @(negedge clk);
      drive(rd(5'd12));
      #2;
      if (issue_o) got_issue = 1'b1;
      else if (stall_o) stalls++;
    end
    chk("poll.issued", 32'(got_issue), 32'd1);
    chk("poll.stalls", 32'(stalls), 32'd3);
    chk("poll.stall_cnt", stall_cnt_o, 32'd3);

    @(negedge clk);
    drive(idle());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
